key_debounce: RTL and testbench

Debounces one raw mechanical push-button and presents a clean pressed level to the downstream edge-capturing PIO input port. It also produces one-cycle event strobes for press, release and long-press. One instance sits between each board key pin and its PIO `in_port` in the Qsys GUI test system. It runs in the 50 MHz system clock domain.

---
 rtl/key_debounce.sv | 152 +++++++++++++++
 tb/tb_key_debounce.sv | 126 ++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: conditions one raw push-button pin into a clean pressed level
// plus one-cycle press, release and long-press strobes. 2-flop synchronizer,
// 4-state debounce FSM with a shared counter, and a saturating hold counter.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    // DEBOUNCE_CYCLES >= 2, so the counter is always at least one bit wide.
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = (LONG_PRESS_CYCLES == 0) ? 1 : $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              sync1_q, sync2_q;
    logic              pressed_raw, pressed_s;
    logic              key_level_q, key_level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    assign pressed_raw = ACTIVE_LOW ? ~key_in : key_in;
    assign pressed_s   = sync2_q;

    // Two-flop synchronizer on the polarity-normalized pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pressed_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_cnt_q  <= '0;
            key_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            key_level_q <= key_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    // Next-state logic: a WAIT state restarts on any opposite sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        key_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // Hold counter: saturates, and the strobe is suppressed when the release
    // is accepted on the same edge so the two never coincide.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_d     = 1'b0;
        if (!key_level_q) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        if ((LONG_PRESS_CYCLES != 0) && key_level_q && key_level_d &&
            (hold_cnt_d == HOLD_MAX) && (hold_cnt_q != HOLD_MAX)) begin
            long_d = 1'b1;
        end
    end

    assign key_level        = key_level_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign long_press_pulse = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10,
// ACTIVE_LOW=1. Each step drives inputs, waits one rising edge, then checks
// {key_level, press_pulse, release_pulse, long_press_pulse} 1 ns later.
module tb_key_debounce;

    logic clk = 1'b0;
    logic reset;
    logic key_in;
    logic key_level, press_pulse, release_pulse, long_press_pulse;

    int checks   = 0;
    int failures = 0;

    key_debounce #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(10),
        .ACTIVE_LOW       (1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .key_in          (key_in),
        .key_level       (key_level),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press_pulse(long_press_pulse)
    );

    always #5 clk = ~clk;

    // exp = {key_level, press_pulse, release_pulse, long_press_pulse}
    typedef struct {
        logic       rst;
        logic       key;
        logic [3:0] exp;
    } vec_t;

    localparam int NVEC = 29;
    vec_t tbl[NVEC];

    task automatic fill(input int lo, input int hi, input logic r, input logic k,
                        input logic [3:0] e);
        for (int i = lo; i <= hi; i++) begin
            tbl[i].rst = r;
            tbl[i].key = k;
            tbl[i].exp = e;
        end
    endtask

    task automatic step(input logic r, input logic k, input logic [3:0] e,
                        input string nm);
        logic [3:0] act;
        reset  = r;
        key_in = k;
        @(posedge clk);
        #1;
        act = {key_level, press_pulse, release_pulse, long_press_pulse};
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: got lvl/prs/rel/long=%b expected %b", nm, act, e);
        end
    endtask

    task automatic run(input int n, input logic r, input logic k,
                       input logic [3:0] e, input string nm);
        for (int i = 0; i < n; i++) step(r, k, e, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        key_in = 1'b0;

        // Reset held with key pressed, press re-debounced after release of
        // reset, release bounce during the hold, long-press, clean release.
        fill(0,  2,  1'b1, 1'b0, 4'b0000);
        fill(3,  7,  1'b0, 1'b0, 4'b0000);
        fill(8,  8,  1'b0, 1'b0, 4'b1100);
        fill(9,  9,  1'b0, 1'b0, 4'b1000);
        fill(10, 11, 1'b0, 1'b1, 4'b1000);
        fill(12, 17, 1'b0, 1'b0, 4'b1000);
        fill(18, 18, 1'b0, 1'b0, 4'b1001);
        fill(19, 20, 1'b0, 1'b0, 4'b1000);
        fill(21, 25, 1'b0, 1'b1, 4'b1000);
        fill(26, 26, 1'b0, 1'b1, 4'b0010);
        fill(27, 28, 1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].rst, tbl[i].key, tbl[i].exp, $sformatf("table[%0d]", i));
        end

        // Press bounce: 3 low, 1 high, then low steady.
        run(3, 1'b0, 1'b0, 4'b0000, "press_bounce_a");
        run(1, 1'b0, 1'b1, 4'b0000, "press_bounce_glitch");
        run(5, 1'b0, 1'b0, 4'b0000, "press_bounce_wait");
        step(1'b0, 1'b0, 4'b1100, "press_bounce_press");
        run(5, 1'b0, 1'b1, 4'b1000, "press_bounce_relwait");
        step(1'b0, 1'b1, 4'b0010, "press_bounce_release");
        run(2, 1'b0, 1'b1, 4'b0000, "press_bounce_idle");

        // Short press: 8 cycles low, no long-press, level high 8 cycles.
        run(5, 1'b0, 1'b0, 4'b0000, "short_wait");
        step(1'b0, 1'b0, 4'b1100, "short_press");
        run(2, 1'b0, 1'b0, 4'b1000, "short_held");
        run(5, 1'b0, 1'b1, 4'b1000, "short_relwait");
        step(1'b0, 1'b1, 4'b0010, "short_release");
        run(2, 1'b0, 1'b1, 4'b0000, "short_idle");

        // Reset mid-hold: level drops without release_pulse, press re-fires.
        run(5, 1'b0, 1'b0, 4'b0000, "rsthold_wait");
        step(1'b0, 1'b0, 4'b1100, "rsthold_press");
        step(1'b0, 1'b0, 4'b1000, "rsthold_held");
        run(2, 1'b1, 1'b0, 4'b0000, "rsthold_reset");
        run(5, 1'b0, 1'b0, 4'b0000, "rsthold_rewait");
        step(1'b0, 1'b0, 4'b1100, "rsthold_repress");
        step(1'b0, 1'b0, 4'b1000, "rsthold_reheld");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
